// File: rtl/vga_fb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// nes_vga_pkg : frame-buffer geometry, pixel/address types, arbiter states.
// Rev 1.0
// ============================================================================
package nes_vga_pkg;
  localparam int NES_W = 256;
  localparam int NES_H = 240;

  typedef logic [8:0]  pixel_t;
  typedef logic [15:0] fb_addr_t;  // {row[7:0], col[7:0]}

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// vga_fb_arbiter_if : PPU write port, RAM port, line-buffer port and fetch
// control of the frame-buffer arbiter. Rev 1.0
// ============================================================================
interface vga_fb_arbiter_if;
  import nes_vga_pkg::*;

  logic       fetch_req;
  logic [7:0] fetch_row;
  logic       ppu_wr_valid;
  logic       ppu_wr_ready;
  fb_addr_t   ppu_wr_addr;
  pixel_t     ppu_wr_data;
  fb_addr_t   mem_addr;
  logic       mem_we;
  pixel_t     mem_wdata;
  pixel_t     mem_rdata;
  logic       lb_we;
  logic [7:0] lb_waddr;
  pixel_t     lb_wdata;
  logic       fetch_busy;
  logic       fetch_overrun;

  // Arbiter side
  modport slave (
    input  fetch_req, fetch_row, ppu_wr_valid, ppu_wr_addr, ppu_wr_data, mem_rdata,
    output ppu_wr_ready, mem_addr, mem_we, mem_wdata, lb_we, lb_waddr, lb_wdata,
           fetch_busy, fetch_overrun
  );

  // Requester / RAM / line-buffer side
  modport master (
    output fetch_req, fetch_row, ppu_wr_valid, ppu_wr_addr, ppu_wr_data, mem_rdata,
    input  ppu_wr_ready, mem_addr, mem_we, mem_wdata, lb_we, lb_waddr, lb_wdata,
           fetch_busy, fetch_overrun
  );
endinterface
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// vga_fb_arbiter : shares the single-port NES frame buffer between PPU writes
// and VGA row prefetch. Optional macro FB_WRITE_GUARD_EN drops rows >= 240.
// Rev 1.0
// ============================================================================
module vga_fb_arbiter
  import nes_vga_pkg::*;
#(
  parameter int WR_SLOT_PERIOD = 4  // 2..8
) (
  input  wire logic       pix_clk,
  input  wire logic       rst,
  vga_fb_arbiter_if.slave bus
);

  localparam int               SLOT_W    = (WR_SLOT_PERIOD > 1) ? $clog2(WR_SLOT_PERIOD) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WR_SLOT_PERIOD - 1);
  localparam logic [7:0]        COL_LAST  = 8'(NES_W - 1);

  arb_state_t        state;
  logic [7:0]        row;
  logic [7:0]        col;
  logic [7:0]        lb_col;
  logic [SLOT_W-1:0] slot;
  logic              lb_pend;
  logic              overrun;

  logic wr_row_ok;
  logic wr_issue;
  logic rd_issue;

`ifdef FB_WRITE_GUARD_EN
  assign wr_row_ok = (bus.ppu_wr_addr[15:8] < 8'(NES_H));
`else
  assign wr_row_ok = 1'b1;
`endif

  // Ready is a function of registered state only, never of ppu_wr_valid.
  assign bus.ppu_wr_ready = (state != ST_FETCH) || (slot == SLOT_LAST);
  assign wr_issue         = bus.ppu_wr_ready && bus.ppu_wr_valid && wr_row_ok;
  // An unused or guarded PPU slot falls back to a read so no slot is lost.
  assign rd_issue         = (state == ST_FETCH) && !wr_issue;

  assign bus.mem_we    = wr_issue;
  assign bus.mem_addr  = wr_issue ? bus.ppu_wr_addr :
                         rd_issue ? {row, col} : '0;
  assign bus.mem_wdata = wr_issue ? bus.ppu_wr_data : '0;

  assign bus.lb_we         = lb_pend;
  assign bus.lb_waddr      = lb_col;
  assign bus.lb_wdata      = bus.mem_rdata;
  assign bus.fetch_busy    = (state != ST_IDLE);
  assign bus.fetch_overrun = overrun;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      row     <= '0;
      col     <= '0;
      slot    <= '0;
      lb_col  <= '0;
      lb_pend <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A restart in FETCH discards the read issued in the same cycle.
      lb_pend <= rd_issue && !(bus.fetch_req && (state == ST_FETCH));
      if (rd_issue) begin
        lb_col <= col;
      end

      case (state)
        ST_FETCH: begin
          if (bus.fetch_req) begin
            overrun <= 1'b1;
            row     <= bus.fetch_row;
            col     <= '0;
            slot    <= '0;
          end else begin
            slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
            if (rd_issue) begin
              col <= col + 8'd1;
              if (col == COL_LAST) begin
                state <= ST_DRAIN;
              end
            end
          end
        end
        default: begin  // IDLE and DRAIN both accept a new fetch
          if (bus.fetch_req) begin
            state <= ST_FETCH;
            row   <= bus.fetch_row;
            col   <= '0;
            slot  <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vga_fb_arbiter : self-checking bench for vga_fb_arbiter against a
// cycle-count model of the scheduling rules. Rev 1.0
// ============================================================================
module tb_vga_fb_arbiter;
  import nes_vga_pkg::*;

  localparam int P = 4;
`ifdef FB_WRITE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic pix_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 pix_clk = ~pix_clk;

  vga_fb_arbiter_if bus();

  vga_fb_arbiter #(.WR_SLOT_PERIOD(P)) dut (
    .pix_clk (pix_clk),
    .rst     (rst),
    .bus     (bus)
  );

  // Physical RAM (driven by DUT) and the model's view of it
  pixel_t ram     [0:65535];
  pixel_t exp_ram [0:65535];

  always @(posedge pix_clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: ph 0=idle 1=fetching 2=drain; mk = cycles into the current fetch
  int     ph, mk, mrow, mreads;
  bit     mover;
  bit     elb_v;
  int     elb_col;
  pixel_t elb_data;
  bit     last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ph = 0; mk = 0; mrow = 0; mreads = 0; mover = 0; elb_v = 0; elb_col = 0; elb_data = '0;
  endtask

  task automatic model_step(input bit fr, input logic [7:0] frow, input bit v,
                            input logic [15:0] a, input logic [8:0] d);
    bit rdy, ok, wr, rd;
    rdy = (ph != 1) || (mk % P == 0);
    ok  = GUARD ? (a[15:8] < 8'd240) : 1'b1;
    wr  = v && rdy && ok;
    rd  = (ph == 1) && !wr;
    last_acc = v && rdy;

    chk("ppu_wr_ready", bus.ppu_wr_ready, rdy);
    chk("mem_we", bus.mem_we, wr);
    if (wr) begin
      chk("mem_addr_wr", bus.mem_addr, a);
      chk("mem_wdata", bus.mem_wdata, d);
    end
    if (rd) chk("mem_addr_rd", bus.mem_addr, {mrow[7:0], mreads[7:0]});
    chk("lb_we", bus.lb_we, elb_v);
    if (elb_v) begin
      chk("lb_waddr", bus.lb_waddr, elb_col);
      chk("lb_wdata", bus.lb_wdata, elb_data);
    end
    chk("fetch_busy", bus.fetch_busy, ph != 0);
    chk("fetch_overrun", bus.fetch_overrun, mover);

    elb_v    = rd && !(fr && ph == 1);
    elb_col  = mreads;
    elb_data = exp_ram[{mrow[7:0], mreads[7:0]}];
    if (wr) exp_ram[a] = d;

    if (ph == 1) begin
      if (fr) begin
        mover = 1; mrow = frow; mreads = 0; mk = 1;
      end else begin
        if (rd) mreads++;
        mk++;
        if (mreads == NES_W) ph = 2;
      end
    end else if (fr) begin
      ph = 1; mrow = frow; mreads = 0; mk = 1;
    end else begin
      ph = 0;
    end
  endtask

  task automatic cycle(input bit fr, input logic [7:0] frow, input bit v,
                       input logic [15:0] a, input logic [8:0] d);
    @(posedge pix_clk); #1;
    bus.fetch_req    = fr;
    bus.fetch_row    = frow;
    bus.ppu_wr_valid = v;
    bus.ppu_wr_addr  = a;
    bus.ppu_wr_data  = d;
    #1;
    cyc++;
    model_step(fr, frow, v, a, d);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 8'd0, 1'b0, 16'h0000, 9'h000);
  endtask

  task automatic do_reset();
    @(posedge pix_clk); #1;
    rst = 1'b1;
    bus.fetch_req = 0; bus.fetch_row = 0; bus.ppu_wr_valid = 0;
    bus.ppu_wr_addr = 0; bus.ppu_wr_data = 0;
    @(posedge pix_clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", bus.ppu_wr_ready, 1);
    chk("rst_lb_we", bus.lb_we, 0);
    chk("rst_busy", bus.fetch_busy, 0);
    chk("rst_overrun", bus.fetch_overrun, 0);
    chk("rst_mem_we", bus.mem_we, 0);
  endtask

  typedef struct {
    bit          v;
    logic [15:0] a;
    logic [8:0]  d;
    bit          e_rdy;
    bit          e_we;
  } vec_t;

  vec_t tv [6];

  initial begin
    int first_lb, last_lb, nlb, nacc, bad;
    logic [15:0] ra;

    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 9'(((i >> 8) * 7) + (i & 255));
      exp_ram[i] = ram[i];
    end
    bus.fetch_req = 0; bus.fetch_row = 0; bus.ppu_wr_valid = 0;
    bus.ppu_wr_addr = 0; bus.ppu_wr_data = 0;
    model_reset();

    do_reset();

    // Idle writes, including the row-240 boundary
    tv[0] = '{1'b1, 16'h1234, 9'h1FF, 1'b1, 1'b1};
    tv[1] = '{1'b0, 16'h2222, 9'h055, 1'b1, 1'b0};
    tv[2] = '{1'b1, 16'hEF00, 9'h001, 1'b1, 1'b1};
    tv[3] = '{1'b1, 16'hF000, 9'h0AA, 1'b1, !GUARD};
    tv[4] = '{1'b1, 16'hFFFF, 9'h100, 1'b1, !GUARD};
    tv[5] = '{1'b1, 16'h0000, 9'h000, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 8'd0, tv[i].v, tv[i].a, tv[i].d);
      chk("vec_ready", bus.ppu_wr_ready, tv[i].e_rdy);
      chk("vec_mem_we", bus.mem_we, tv[i].e_we);
      if (tv[i].e_we) begin
        chk("vec_mem_addr", bus.mem_addr, tv[i].a);
        chk("vec_mem_wdata", bus.mem_wdata, tv[i].d);
      end
    end
    idle_cycle();
    chk("ram_0x1234", ram[16'h1234], 9'h1FF);

    // Clean fetch of row 5
    cycle(1'b1, 8'd5, 1'b0, 16'h0, 9'h0);
    first_lb = -1; last_lb = -1; nlb = 0;
    for (int n = 1; n <= 260; n++) begin
      idle_cycle();
      if (bus.lb_we === 1'b1) begin
        if (first_lb < 0) first_lb = n;
        last_lb = n;
        nlb++;
      end
      if (n == 257) chk("clean_busy_257", bus.fetch_busy, 1);
      if (n == 258) chk("clean_busy_258", bus.fetch_busy, 0);
    end
    chk("clean_first_lb", first_lb, 2);
    chk("clean_last_lb", last_lb, 257);
    chk("clean_lb_count", nlb, 256);

    // Fetch of row 7 under continuous PPU traffic; fetch_req coincides with a write
    cycle(1'b1, 8'd7, 1'b1, 16'h3300, 9'h0F0);
    chk("idle_req_and_write_we", bus.mem_we, 1);
    last_lb = -1; nacc = 0;
    for (int n = 1; n <= 345; n++) begin
      ra = 16'($urandom);
      cycle(1'b0, 8'd0, 1'b1, ra, 9'($urandom));
      if (n <= 341 && last_acc) nacc++;
      if (bus.lb_we === 1'b1) last_lb = n;
    end
    chk("cont_accepts", nacc, 85);
    chk("cont_last_lb", last_lb, 342);

    // fetch_req during DRAIN: no overrun, drain write kept
    cycle(1'b1, 8'd3, 1'b0, 16'h0, 9'h0);
    for (int n = 1; n <= 256; n++) idle_cycle();
    cycle(1'b1, 8'd4, 1'b0, 16'h0, 9'h0);
    chk("drain_lb_we", bus.lb_we, 1);
    chk("drain_lb_waddr", bus.lb_waddr, 255);
    idle_cycle();
    chk("drain_refetch_busy", bus.fetch_busy, 1);
    chk("drain_no_overrun", bus.fetch_overrun, 0);
    for (int n = 0; n < 262; n++) idle_cycle();

    // fetch_req in FETCH at cycle 100 -> overrun, restart, stale write dropped
    cycle(1'b1, 8'd10, 1'b0, 16'h0, 9'h0);
    for (int n = 1; n <= 99; n++) idle_cycle();
    cycle(1'b1, 8'd20, 1'b0, 16'h0, 9'h0);
    idle_cycle();
    chk("ovr_lb_we_101", bus.lb_we, 0);
    chk("ovr_flag_101", bus.fetch_overrun, 1);
    idle_cycle();
    chk("ovr_lb_we_102", bus.lb_we, 1);
    chk("ovr_lb_waddr_102", bus.lb_waddr, 0);
    chk("ovr_lb_wdata_102", bus.lb_wdata, exp_ram[16'h1400]);
    for (int n = 0; n < 270; n++) idle_cycle();
    chk("ovr_sticky", bus.fetch_overrun, 1);

    // Reset at cycle 50 of a fetch
    cycle(1'b1, 8'd9, 1'b0, 16'h0, 9'h0);
    for (int n = 1; n < 50; n++) idle_cycle();
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(0, 399) == 0), 8'($urandom_range(0, 239)),
            1'($urandom_range(0, 1)), 16'($urandom), 9'($urandom));
    end
    for (int n = 0; n < 300; n++) idle_cycle();

    bad = 0;
    for (int i = 0; i < 65536; i++) if (ram[i] !== exp_ram[i]) bad++;
    chk("ram_contents_bad_words", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
